mem_burst_reader: RTL
=====================

# mem_burst_reader

Requester-side read master for one port of the shared multi-port memory. It accepts a burst command (start address, word count) and issues one word read per accepted address handshake on its memory read port. It collects the returned words in a local FIFO and presents them as a valid/ready stream with a last marker. A credit counter guarantees that returned data can never overflow the FIFO, because the memory read data path has no backpressure.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 4, memory address width; a burst covers up to 2^ADDR_WIDTH words
- FIFO_DEPTH, 4, response FIFO depth and maximum in-flight words (>=2, power of two)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; shared with the memory
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_addr  in  ADDR_WIDTH  first word address
- cmd_len  in  ADDR_WIDTH  burst length minus one (0 = 1 word)
- r_addr  out  ADDR_WIDTH  memory read address
- r_avalid  out  1  memory read request
- r_aready  in  1  memory grant; address accepted when r_avalid && r_aready
- r_dvalid  in  1  memory read data valid for this port
- r_data  in  DATA_WIDTH  memory read data
- out_valid  out  1  stream word valid
- out_ready  in  1  stream consumer ready
- out_data  out  DATA_WIDTH  stream word
- out_last  out  1  marks the final word of the burst
- err  out  1  sticky: r_dvalid seen with nothing outstanding

## Operation
- States:
  - IDLE: cmd_ready=1.
  - ISSUE: addresses are being issued.
  - DRAIN: all addresses are accepted; waiting for the last word to be popped.
- IDLE -> ISSUE on command handshake.
  - Latches the address pointer = cmd_addr.
  - Latches remaining = cmd_len+1 (ADDR_WIDTH+1 bits).
  - Latches out_beats = cmd_len+1.
- ISSUE behaviour:
  - r_avalid = (credits_used < FIFO_DEPTH).
  - credits_used = outstanding + fifo_count, width $clog2(FIFO_DEPTH+1).
  - On each address handshake: pointer +1, wrapping modulo 2^ADDR_WIDTH (0xF -> 0x0 at default width); remaining -1; outstanding +1.
  - When the handshake takes remaining to 0, go to DRAIN.
- Stability: r_avalid, once high, stays high until the handshake, with r_addr stable. This holds because credits only shrink by issuing.
- Response path: on r_dvalid, r_data is written to the FIFO and outstanding decrements. If r_dvalid and a handshake occur in the same cycle, outstanding is unchanged.
- Output stream:
  - out_valid = FIFO not empty.
  - Pop on out_valid && out_ready.
  - out_last = out_valid && (out_beats == 1); out_beats decrements on each pop.
- DRAIN -> IDLE on the pop with out_last.
- Simultaneous pop and write: FIFO count is unchanged and no data is lost, including when the FIFO is full.
- r_dvalid with outstanding == 0:
  - Data is dropped.
  - err sets and stays set until rst.
- Outside ISSUE: r_avalid=0 and r_addr=0.
- The block makes no assumption about memory latency. Any latency >=1 is correct.

## Timing
- Reset state:
  - State = IDLE.
  - FIFO, outstanding, pointer and counters are cleared.
  - Output values during reset: cmd_ready=0 (forced low while rst), r_avalid=0, r_addr=0, out_valid=0, out_last=0, out_data=0, err=0.
  - cmd_ready=1 from the first cycle after rst deasserts.
- Command handshake in cycle N: r_avalid is high in cycle N+1, provided credits are available.
- FIFO timing: a word sampled with r_dvalid in cycle M appears on out_valid/out_data in cycle M+1 (registered write, first-word-fall-through read).
- Back-to-back issue: one address per cycle while r_aready=1 and credits remain.
- Throughput: 1 word/cycle in steady state when FIFO_DEPTH >= memory latency + 1.
- Next command: may be accepted in the cycle after the last-word pop.
- rst mid-burst: takes effect at the next edge, abandoning the burst. No residual out_valid and no err from in-flight words, because the memory resets on the same rst.

## Test plan
- cmd_addr=3, cmd_len=3, memory[3..6]=A0..A3, out_ready=1, r_aready=1 -> r_addr 3,4,5,6 on consecutive cycles; out_data A0..A3 on consecutive cycles; out_last only with A3; back to IDLE.
- Wrap: cmd_addr=14, cmd_len=3 -> addresses 14,15,0,1 issued; 4 words returned in order.
- Backpressure: cmd_len=15, out_ready=0 -> exactly FIFO_DEPTH=4 address handshakes, then r_avalid=0 with r_addr held. Raising out_ready resumes issue; all 16 words arrive in order with no loss.
- Arbitration stall: r_aready low for 3 cycles while r_avalid=1 -> r_addr stable throughout; handshake completes when r_aready rises.
- Spurious r_dvalid in IDLE -> err=1 one cycle later; no out_valid. err remains 1 until rst.
- rst asserted after 2 of 8 words issued -> next cycle all outputs at reset values; cmd_ready=1 after release; a new 1-word burst completes correctly.

Source files
------------

// File: rtl/mem_burst_reader_if.sv
// mem_burst_reader_if
// Bundles every signal of the burst reader except clk/rst:
//   cmd_*  : burst command (start address, length-1) with valid/ready
//   r_*    : memory read port (address request/grant, returned data)
//   out_*  : response stream with last marker
//   err    : sticky flag for read data returned with nothing outstanding
// Modports:
//   master : the reader itself
//   slave  : the environment (command source, memory, stream consumer)
interface mem_burst_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_avalid;
  logic                  r_aready;
  logic                  r_dvalid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, r_aready, r_dvalid, r_data, out_ready,
    output cmd_ready, r_addr, r_avalid, out_valid, out_data, out_last, err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, r_aready, r_dvalid, r_data, out_ready,
    input  cmd_ready, r_addr, r_avalid, out_valid, out_data, out_last, err
  );
endinterface

// File: rtl/mem_burst_reader.sv
// mem_burst_reader
// Read master for one port of a shared memory. Accepts a burst command,
// issues one read address per granted request, buffers returned words in a
// small first-word-fall-through FIFO and streams them out with a last marker.
// A credit scheme (outstanding reads + FIFO occupancy <= FIFO_DEPTH) ensures
// returned data always has room, since the memory data path cannot stall.
// Ports:
//   clk, rst : clock, synchronous active-high reset (shared with the memory)
//   bus      : mem_burst_reader_if.master (command, memory read port,
//              output stream, sticky err)
module mem_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_burst_reader_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0]      DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
  logic [ADDR_WIDTH:0]   remaining_reg, remaining_next;
  logic [ADDR_WIDTH:0]   out_beats_reg, out_beats_next;
  logic [CNT_W-1:0]      outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic                  err_reg;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic [CNT_W:0] credits_used;
  logic           cmd_ready;
  logic           cmd_hs;
  logic           r_avalid;
  logic           addr_hs;
  logic           wr_en;
  logic           spurious;
  logic           out_valid;
  logic           out_last;
  logic           pop;

  // Credits cover both words still in flight and words already buffered.
  assign credits_used = {1'b0, outstanding_reg} + {1'b0, count_reg};

  assign cmd_ready = (state_reg == ST_IDLE) && !rst;
  assign cmd_hs    = bus.cmd_valid && cmd_ready;
  // Credits can only shrink by issuing, so once raised r_avalid holds until
  // its handshake and the address stays put.
  assign r_avalid  = (state_reg == ST_ISSUE) && (credits_used < DEPTH_C);
  assign addr_hs   = r_avalid && bus.r_aready;

  // Data with nothing outstanding cannot belong to us: drop it, flag it.
  assign wr_en    = bus.r_dvalid && (outstanding_reg != '0);
  assign spurious = bus.r_dvalid && (outstanding_reg == '0);

  assign out_valid = (count_reg != '0);
  assign out_last  = out_valid && (out_beats_reg == ONE_W);
  assign pop       = out_valid && bus.out_ready;

  assign bus.cmd_ready = cmd_ready;
  assign bus.r_avalid  = r_avalid;
  assign bus.r_addr    = (state_reg == ST_ISSUE) ? ptr_reg : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  // Gate with out_valid so stale RAM contents never show on the stream.
  assign bus.out_data  = out_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign bus.err       = err_reg;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    out_beats_next = out_beats_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_hs) begin
          state_next     = ST_ISSUE;
          ptr_next       = bus.cmd_addr;
          remaining_next = {1'b0, bus.cmd_len} + ONE_W;
          out_beats_next = {1'b0, bus.cmd_len} + ONE_W;
        end
      end
      ST_ISSUE: begin
        if (addr_hs) begin
          ptr_next       = ptr_reg + 1'b1;   // wraps modulo 2^ADDR_WIDTH
          remaining_next = remaining_reg - ONE_W;
          if (remaining_reg == ONE_W) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
      end
      default: state_next = ST_IDLE;
    endcase
    if (pop) begin
      out_beats_next = out_beats_reg - ONE_W;
      // The last word can only be popped after every address was issued.
      if (out_last && (state_reg == ST_DRAIN)) begin
        state_next = ST_IDLE;
      end
    end
  end

  always_comb begin
    outstanding_next = outstanding_reg;
    case ({addr_hs, wr_en})
      2'b10:   outstanding_next = outstanding_reg + 1'b1;
      2'b01:   outstanding_next = outstanding_reg - 1'b1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({wr_en, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      ptr_reg         <= '0;
      remaining_reg   <= '0;
      out_beats_reg   <= '0;
      outstanding_reg <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      remaining_reg   <= remaining_next;
      out_beats_reg   <= out_beats_next;
      outstanding_reg <= outstanding_next;
      count_reg       <= count_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (spurious) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Storage has no reset; occupancy is tracked by count_reg. A write while
  // full and popping lands on the slot being read out this same cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= bus.r_data;
    end
  end

endmodule
